multdiv_exec_unit: RTL and testbench
====================================

MULTDIV_EXEC_UNIT -- requirements
Module: multdiv_exec_unit

Interface
REQ-001 Port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-002 Port reset, input, 1: synchronous, active-low; sampled only on the rising edge of clock.
REQ-003 Port start, input, 1: X stage issues the instruction on instr_in.
REQ-004 Port instr_in, input, 32: instruction word; opcode [31:27], rd [26:22], ALU op [6:2].
REQ-005 Port operandA, input, 32: rs value, two's complement.
REQ-006 Port operandB, input, 32: rt value, two's complement.
REQ-007 Port flush, input, 1: kill any in-flight operation.
REQ-008 Port wb_ack, input, 1: writeback stage has consumed the result.
REQ-009 Port busy, output, 1: high in any state other than IDLE.
REQ-010 Port P_instr, output, 32: in-flight instruction word for hazard control; 0 (NOP) when idle.
REQ-011 Port result_valid, output, 1: result, wb_rd and exc_valid are valid.
REQ-012 Port result, output, 32: product, quotient, or exception code.
REQ-013 Port wb_rd, output, 5: destination register.
REQ-014 Port exc_valid, output, 1: result is an exception status write.

Function
REQ-015 States SHALL be IDLE, MUL, DIV and DONE.
REQ-016 Accepted operation: in IDLE with start=1, flush=0, opcode=00000, and ALU op 00110 (mul) or 00111 (div).
- start with any other instruction is ignored.
- start in any state other than IDLE is ignored.
REQ-017 On the accepting edge, the unit SHALL:
- latch instr_in into P_instr, and operandA and operandB;
- clear the 5-bit iteration counter;
- enter MUL or DIV.
REQ-018 MUL/DIV SHALL perform one iteration per edge, incrementing the counter; it moves to DONE on the edge where counter==31 (32 iterations).
- result_valid is first high after the 32nd edge following the accepting edge.
REQ-019 Multiply SHALL be iterative shift-add (Booth permitted) forming a 64-bit signed product.
- result = low 32 bits.
- Overflow when the high 32 bits are not the sign extension of bit 31.
REQ-020 Divide SHALL be 32-step restoring division on magnitudes, quotient negated if operand signs differ, truncating toward zero.
- 0x80000000 / -1 yields 0x80000000 with no exception.
REQ-021 Divide with operandB==0 SHALL skip iteration: DIV moves to DONE on the first edge after accept.
REQ-022 In DONE:
- result_valid=1.
- Outputs are held stable until wb_ack=1.
- On that edge the unit returns to IDLE and P_instr clears to 0.
REQ-023 Normal completion: wb_rd = P_instr[26:22], exc_valid=0.
REQ-024 Exception completion: wb_rd=30, exc_valid=1.
- result=4 on multiply overflow.
- result=5 on divide by zero.
REQ-025 flush=1 in any state SHALL force IDLE on that edge and clear P_instr; no result_valid is produced.
- flush outranks start and wb_ack.
REQ-026 In DONE, simultaneous wb_ack and start: wb_ack retires the operation; start is ignored (busy=1 that cycle).
REQ-027 result_valid, exc_valid and wb_rd SHALL be 0 in every state except DONE.
- result reads 0 outside DONE.

Reset
REQ-028 reset=0 at a rising edge SHALL, regardless of state or other inputs:
- force IDLE;
- clear the counter and all datapath registers;
- drive busy, P_instr, result_valid, result, wb_rd and exc_valid to 0 from the following cycle.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no result_valid pulse after reset releases.

Verification
REQ-030 The bench SHALL cover these scenarios:
- mul rd=5, A=7, B=-6 -> after 32 edges: result_valid=1, result=0xFFFFFFD6, wb_rd=5, exc_valid=0.
- mul A=0x00010000, B=0x00010000 -> wb_rd=30, result=4, exc_valid=1.
- div rd=9, A=-100, B=7 -> result=0xFFFFFFF2 (-14), wb_rd=9, after 32 edges.
- div A=123, B=0 -> DONE one edge after accept; wb_rd=30, result=5, exc_valid=1.
- flush after 10 iterations of a mul -> next cycle busy=0, P_instr=0; no result_valid ever.
- wb_ack held low 5 cycles in DONE, with start pulsed -> result stable; start ignored; IDLE one edge after wb_ack.
- reset low during DIV -> all outputs 0 next cycle; no result_valid.

Source files
------------

// File: rtl/multdiv_exec_unit.sv
// Iterative 32-bit signed multiply/divide execution unit.
// Multiply: 32-step shift-add on operand magnitudes; the 64-bit product is
// negated when the operand signs differ and checked for 32-bit overflow.
// Divide: 32-step restoring division on magnitudes; the quotient is negated
// when the operand signs differ (truncation toward zero).
// The completed result is held in DONE until writeback acknowledges it.
module multdiv_exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr_in,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    input  logic        wb_ack,
    output logic        busy,
    output logic [31:0] P_instr,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  wb_rd,
    output logic        exc_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0]  EXC_RD       = 5'd30;
    localparam logic [31:0] EXC_MUL_OVF  = 32'd4;
    localparam logic [31:0] EXC_DIV_ZERO = 32'd5;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [64:0] work_q;     // mul: {hi[32:0], multiplier/low}; div: {rem[32:0], quotient}
    logic [31:0] opnd_q;     // mul: |A| (multiplicand); div: |B| (divisor)
    logic        neg_q;      // operand signs differ
    logic        busy_q;
    logic [31:0] p_instr_q;
    logic        result_valid_q;
    logic [31:0] result_q;
    logic [4:0]  wb_rd_q;
    logic        exc_valid_q;

    logic        is_mul_s;
    logic        is_div_s;
    logic [32:0] mul_sum_s;
    logic [64:0] mul_work_d;
    logic [63:0] mul_prod_s;
    logic        mul_ovf_s;
    logic [64:0] div_shift_s;
    logic [33:0] div_diff_s;
    logic [64:0] div_work_d;
    logic [31:0] div_quo_s;

    // Two's-complement magnitude; 0x80000000 maps to 0x80000000 read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        mag32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    // Decode an issued instruction as mul or div.
    always_comb begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
        if (instr_in[31:27] == 5'b00000) begin
            if (instr_in[6:2] == 5'b00110) begin
                is_mul_s = 1'b1;
            end else if (instr_in[6:2] == 5'b00111) begin
                is_div_s = 1'b1;
            end else begin
                is_mul_s = 1'b0;
                is_div_s = 1'b0;
            end
        end else begin
            is_mul_s = 1'b0;
            is_div_s = 1'b0;
        end
    end

    // One multiply iteration: conditionally add multiplicand into the high half, then shift right.
    always_comb begin
        if (work_q[0]) begin
            mul_sum_s = work_q[64:32] + {1'b0, opnd_q};
        end else begin
            mul_sum_s = work_q[64:32];
        end
        mul_work_d = {1'b0, mul_sum_s, work_q[31:1]};
        if (neg_q) begin
            mul_prod_s = ~mul_work_d[63:0] + 64'd1;
        end else begin
            mul_prod_s = mul_work_d[63:0];
        end
        mul_ovf_s = (mul_prod_s[63:32] != {32{mul_prod_s[31]}});
    end

    // One restoring-division iteration: shift left, trial-subtract divisor, keep if non-negative.
    always_comb begin
        div_shift_s = {work_q[63:0], 1'b0};
        div_diff_s  = {1'b0, div_shift_s[64:32]} - {2'b00, opnd_q};
        if (!div_diff_s[33]) begin
            div_work_d = {div_diff_s[32:0], div_shift_s[31:1], 1'b1};
        end else begin
            div_work_d = div_shift_s;
        end
        if (neg_q) begin
            div_quo_s = ~div_work_d[31:0] + 32'd1;
        end else begin
            div_quo_s = div_work_d[31:0];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 5'd0;
            work_q         <= 65'd0;
            opnd_q         <= 32'd0;
            neg_q          <= 1'b0;
            busy_q         <= 1'b0;
            p_instr_q      <= 32'd0;
            result_valid_q <= 1'b0;
            result_q       <= 32'd0;
            wb_rd_q        <= 5'd0;
            exc_valid_q    <= 1'b0;
        end else if (flush) begin
            state_q        <= S_IDLE;
            cnt_q          <= 5'd0;
            work_q         <= 65'd0;
            opnd_q         <= 32'd0;
            neg_q          <= 1'b0;
            busy_q         <= 1'b0;
            p_instr_q      <= 32'd0;
            result_valid_q <= 1'b0;
            result_q       <= 32'd0;
            wb_rd_q        <= 5'd0;
            exc_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (is_mul_s || is_div_s)) begin
                        p_instr_q <= instr_in;
                        cnt_q     <= 5'd0;
                        busy_q    <= 1'b1;
                        neg_q     <= operandA[31] ^ operandB[31];
                        if (is_mul_s) begin
                            work_q  <= {33'd0, mag32(operandB)};
                            opnd_q  <= mag32(operandA);
                            state_q <= S_MUL;
                        end else begin
                            work_q  <= {33'd0, mag32(operandA)};
                            opnd_q  <= mag32(operandB);
                            state_q <= S_DIV;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    work_q <= mul_work_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q        <= S_DONE;
                        result_valid_q <= 1'b1;
                        if (mul_ovf_s) begin
                            result_q    <= EXC_MUL_OVF;
                            wb_rd_q     <= EXC_RD;
                            exc_valid_q <= 1'b1;
                        end else begin
                            result_q    <= mul_prod_s[31:0];
                            wb_rd_q     <= p_instr_q[26:22];
                            exc_valid_q <= 1'b0;
                        end
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_DIV: begin
                    if (opnd_q == 32'd0) begin
                        // Divide by zero: no iterations, report the exception directly.
                        state_q        <= S_DONE;
                        result_valid_q <= 1'b1;
                        result_q       <= EXC_DIV_ZERO;
                        wb_rd_q        <= EXC_RD;
                        exc_valid_q    <= 1'b1;
                    end else begin
                        work_q <= div_work_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q        <= S_DONE;
                            result_valid_q <= 1'b1;
                            result_q       <= div_quo_s;
                            wb_rd_q        <= p_instr_q[26:22];
                            exc_valid_q    <= 1'b0;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DONE: begin
                    if (wb_ack) begin
                        state_q        <= S_IDLE;
                        busy_q         <= 1'b0;
                        p_instr_q      <= 32'd0;
                        result_valid_q <= 1'b0;
                        result_q       <= 32'd0;
                        wb_rd_q        <= 5'd0;
                        exc_valid_q    <= 1'b0;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    busy_q         <= 1'b0;
                    p_instr_q      <= 32'd0;
                    result_valid_q <= 1'b0;
                    result_q       <= 32'd0;
                    wb_rd_q        <= 5'd0;
                    exc_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign P_instr      = p_instr_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign wb_rd        = wb_rd_q;
    assign exc_valid    = exc_valid_q;

endmodule

// File: tb/tb_multdiv_exec_unit.sv
// Directed, table-driven bench for multdiv_exec_unit with hand-computed results.
module tb_multdiv_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instr_in;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        flush;
    logic        wb_ack;
    logic        busy;
    logic [31:0] P_instr;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  wb_rd;
    logic        exc_valid;

    int checks = 0;
    int errors = 0;

    multdiv_exec_unit dut (
        .clock(clock), .reset(reset), .start(start), .instr_in(instr_in),
        .operandA(operandA), .operandB(operandB), .flush(flush), .wb_ack(wb_ack),
        .busy(busy), .P_instr(P_instr), .result_valid(result_valid), .result(result),
        .wb_rd(wb_rd), .exc_valid(exc_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_exc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] op);
        mk = {5'b00000, rd, 15'd0, op, 2'b00};
    endfunction

    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".busy"}, {31'd0, busy}, 32'd0);
        chk({name, ".P_instr"}, P_instr, 32'd0);
        chk({name, ".rv"}, {31'd0, result_valid}, 32'd0);
        chk({name, ".result"}, result, 32'd0);
        chk({name, ".wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({name, ".exc"}, {31'd0, exc_valid}, 32'd0);
    endtask

    // Issue one op; the accepting edge is consumed here.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instr_in = ins; operandA = a; operandB = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until result_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        issue(v.instr, v.a, v.b);
        chk({tag, ".busy_acc"}, {31'd0, busy}, 32'd1);
        chk({tag, ".pinstr_acc"}, P_instr, v.instr);
        chk({tag, ".res_acc"}, result, 32'd0);
        wait_valid(n);
        chk({tag, ".latency"}, n, v.exp_lat);
        chk({tag, ".result"}, result, v.exp_res);
        chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, v.exp_rd});
        chk({tag, ".exc"}, {31'd0, exc_valid}, {31'd0, v.exp_exc});
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk_idle({tag, ".retire"});
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] ins_m;
        reset = 1'b0; start = 1'b0; flush = 1'b0; wb_ack = 1'b0;
        instr_in = 32'd0; operandA = 32'd0; operandB = 32'd0;

        vecs[0]  = '{mk(5'd5,  OP_MUL), 32'd7,          32'hFFFFFFFA, 32'hFFFFFFD6, 5'd5,  1'b0, 32};
        vecs[1]  = '{mk(5'd3,  OP_MUL), 32'h00010000,   32'h00010000, 32'd4,        5'd30, 1'b1, 32};
        vecs[2]  = '{mk(5'd9,  OP_DIV), 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 5'd9,  1'b0, 32};
        vecs[3]  = '{mk(5'd1,  OP_DIV), 32'd123,        32'd0,        32'd5,        5'd30, 1'b1, 1};
        vecs[4]  = '{mk(5'd2,  OP_DIV), 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 5'd2,  1'b0, 32};
        vecs[5]  = '{mk(5'd4,  OP_MUL), 32'hFFFFFFFD,   32'hFFFFFFFB, 32'd15,       5'd4,  1'b0, 32};
        vecs[6]  = '{mk(5'd6,  OP_MUL), 32'h80000000,   32'd1,        32'h80000000, 5'd6,  1'b0, 32};
        vecs[7]  = '{mk(5'd7,  OP_MUL), 32'h80000000,   32'hFFFFFFFF, 32'd4,        5'd30, 1'b1, 32};
        vecs[8]  = '{mk(5'd8,  OP_DIV), 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 5'd8,  1'b0, 32};
        vecs[9]  = '{mk(5'd10, OP_DIV), 32'd7,          32'd100,      32'd0,        5'd10, 1'b0, 32};
        vecs[10] = '{mk(5'd11, OP_MUL), 32'h7FFFFFFF,   32'd2,        32'd4,        5'd30, 1'b1, 32};
        vecs[11] = '{mk(5'd12, OP_DIV), 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        5'd12, 1'b0, 32};

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        chk_idle("post_reset");

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Start with a non-mul/div instruction is ignored
        issue({5'b00001, 5'd5, 15'd0, OP_MUL, 2'b00}, 32'd1, 32'd1);
        chk_idle("bad_opcode");
        issue(mk(5'd5, 5'b00101), 32'd1, 32'd1);
        chk_idle("bad_aluop");

        // flush outranks start in IDLE
        flush = 1'b1;
        issue(mk(5'd5, OP_MUL), 32'd3, 32'd3);
        flush = 1'b0;
        chk_idle("flush_vs_start");

        // Flush after 10 multiply iterations
        issue(mk(5'd5, OP_MUL), 32'd7, 32'hFFFFFFFA);
        for (int k = 0; k < 10; k++) tick();
        chk("flush.busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle("flush");
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (result_valid) seen++;
        end
        chk("flush.no_rv", seen, 0);

        // DONE held 5 cycles with start pulsed; retire on wb_ack with start high
        ins_m = mk(5'd5, OP_MUL);
        issue(ins_m, 32'd7, 32'hFFFFFFFA);
        wait_valid(n);
        chk("hold.latency", n, 32);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                instr_in = mk(5'd9, OP_DIV); operandA = 32'd50; operandB = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            chk($sformatf("hold%0d.result", k), result, 32'hFFFFFFD6);
            chk($sformatf("hold%0d.rv", k), {31'd0, result_valid}, 32'd1);
            chk($sformatf("hold%0d.wb_rd", k), {27'd0, wb_rd}, 32'd5);
            chk($sformatf("hold%0d.pinstr", k), P_instr, ins_m);
            chk($sformatf("hold%0d.busy", k), {31'd0, busy}, 32'd1);
        end
        instr_in = mk(5'd9, OP_DIV); start = 1'b1; wb_ack = 1'b1;
        tick();
        start = 1'b0; wb_ack = 1'b0;
        chk_idle("ack_vs_start");
        tick();
        chk_idle("ack_vs_start.after");

        // Reset during DIV
        issue(mk(5'd9, OP_DIV), 32'hFFFFFF9C, 32'd7);
        for (int k = 0; k < 5; k++) tick();
        chk("rst_div.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        chk_idle("rst_div");
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (result_valid || busy) seen++;
        end
        chk("rst_div.no_rv", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
